// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: payload struct, NOP encoding, widths, FSM states.
package fetch_stage_pkg;

   localparam int unsigned PC_W    = 32;
   localparam int unsigned INSTR_W = 32;

   // addi x0, x0, 0
   localparam logic [INSTR_W-1:0] kNOP = 32'h0000_0013;

   typedef struct packed {
      logic [INSTR_W-1:0] instruction_fetchTOdecode;
      logic [PC_W-1:0]    PC_r_fetchTOdecode;
   } fetchTOdecode_s;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO used for the prefetch queue and the in-flight PC-tag queue.
module fetch_buffer
   import fetch_stage_pkg::*;
#(
   parameter int unsigned W     = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic                         pop,
   input  logic                         clear,
   input  logic [W-1:0]                 din,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH):0]       count,
   output logic [W-1:0]                 head
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push_c, do_pop_c;

   // Pointer/count update; clear wins over push and pop
   always_comb begin
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      cnt_d     = cnt_q;
      do_push_c = push && !full;
      do_pop_c  = pop && !empty;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (do_push_c) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (do_pop_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         cnt_d = cnt_q + CW'(do_push_c) - CW'(do_pop_c);
      end
   end

   // Storage and pointer registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign full  = (cnt_q == CW'(DEPTH));
   assign empty = (cnt_q == '0);
   assign count = cnt_q;
   assign head  = mem_q[rd_ptr_q];

   // Credit accounting upstream must keep pushes away from a full FIFO
   assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !clear));

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues in-order imem requests, buffers
// returned words with their PCs and redirects on flush, dropping stale responses.
// Optional perf counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC  = '0,
   parameter logic [PC_W-1:0] PC_INC    = PC_W'(4),
   parameter int unsigned     BUF_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                stall,
   input  logic                itr,
   input  logic                IW,
   input  logic                flush,
   input  logic [PC_W-1:0]     redirect_pc,
   output logic                imem_req_valid,
   input  logic                imem_req_ready,
   output logic [PC_W-1:0]     imem_addr,
   input  logic                imem_rsp_valid,
   input  logic [INSTR_W-1:0]  imem_rsp_data,
   output fetchTOdecode_s      fetchTOdecode_s_o
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]         perf_bubble_cnt,
   output logic [31:0]         perf_discard_cnt
`endif
);
   localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;
   localparam int unsigned SUM_W = CNT_W + 1;
   localparam int unsigned ENT_W = INSTR_W + PC_W;

   fetch_state_e      state_q, state_d;
   logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
   logic [CNT_W-1:0]  outstanding_q, outstanding_d;
   logic [CNT_W-1:0]  discard_q, discard_d;

   logic [SUM_W-1:0]  credit_sum_c;
   logic              req_valid_c, accept_c, drop_c, rsp_push_c, pop_c;

   logic [ENT_W-1:0]  buf_head;
   logic [CNT_W-1:0]  buf_count;
   logic              buf_full, buf_empty;
   logic [PC_W-1:0]   tag_head;
   logic [CNT_W-1:0]  tag_count;
   logic              tag_full, tag_empty;

   // Handshake decode: credits, accept, response routing, consume
   always_comb begin
      credit_sum_c = SUM_W'(buf_count) + SUM_W'(outstanding_q);
      req_valid_c  = (state_q != IDLE) && (credit_sum_c < SUM_W'(BUF_DEPTH)) && !flush;
      accept_c     = req_valid_c && imem_req_ready;
      drop_c       = imem_rsp_valid && (discard_q != '0);
      rsp_push_c   = imem_rsp_valid && (discard_q == '0) && !flush;
      pop_c        = !(stall || itr) && !IW && !flush && !buf_empty;
   end

   // Next PC, in-flight bookkeeping and FSM transitions
   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      discard_d     = discard_q;
      outstanding_d = outstanding_q + CNT_W'(accept_c) - CNT_W'(imem_rsp_valid);
      if (flush) begin
         // Everything still in flight after this cycle belongs to the old path
         fetch_pc_d = redirect_pc;
         discard_d  = outstanding_q - CNT_W'(imem_rsp_valid);
      end else begin
         if (accept_c) fetch_pc_d = fetch_pc_q + PC_INC;
         if (drop_c)   discard_d  = discard_q - CNT_W'(1);
      end
      unique case (state_q)
         IDLE:    state_d = RUN;
         RUN:     if (flush && (discard_d != '0)) state_d = DRAIN;
         DRAIN:   if (discard_d == '0) state_d = RUN;
         default: state_d = IDLE;
      endcase
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         fetch_pc_q    <= RESET_PC;
         outstanding_q <= '0;
         discard_q     <= '0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
      end
   end

   // PC of every accepted request, retired in order as responses return
   fetch_buffer #(.W(PC_W), .DEPTH(BUF_DEPTH)) u_tag_q (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (accept_c),
      .pop   (imem_rsp_valid),
      .clear (1'b0),
      .din   (fetch_pc_q),
      .full  (tag_full),
      .empty (tag_empty),
      .count (tag_count),
      .head  (tag_head)
   );

   // Prefetch queue of {instr, pc}
   fetch_buffer #(.W(ENT_W), .DEPTH(BUF_DEPTH)) u_prefetch_q (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (rsp_push_c),
      .pop   (pop_c),
      .clear (flush),
      .din   ({imem_rsp_data, tag_head}),
      .full  (buf_full),
      .empty (buf_empty),
      .count (buf_count),
      .head  (buf_head)
   );

   // Outputs: request port and decode payload (NOP with current PC when empty)
   always_comb begin
      imem_req_valid = req_valid_c;
      imem_addr      = fetch_pc_q;
      if (buf_empty) begin
         fetchTOdecode_s_o = '{instruction_fetchTOdecode: kNOP, PC_r_fetchTOdecode: fetch_pc_q};
      end else begin
         fetchTOdecode_s_o = fetchTOdecode_s'(buf_head);
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] bubble_cnt_q, bubble_cnt_d, discard_cnt_q, discard_cnt_d;

   // Saturating bubble / dropped-response counters
   always_comb begin
      bubble_cnt_d  = bubble_cnt_q;
      discard_cnt_d = discard_cnt_q;
      if (buf_empty && !(stall || itr || IW || flush) && (bubble_cnt_q != '1))
         bubble_cnt_d = bubble_cnt_q + 32'd1;
      if (drop_c && (discard_cnt_q != '1))
         discard_cnt_d = discard_cnt_q + 32'd1;
   end

   // Counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubble_cnt_q  <= '0;
         discard_cnt_q <= '0;
      end else begin
         bubble_cnt_q  <= bubble_cnt_d;
         discard_cnt_q <= discard_cnt_d;
      end
   end

   assign perf_bubble_cnt  = bubble_cnt_q;
   assign perf_discard_cnt = discard_cnt_q;
`endif

   // Protocol and bookkeeping invariants
   assert property (@(posedge clk) disable iff (!rst_n) !(imem_rsp_valid && tag_empty));
   assert property (@(posedge clk) disable iff (!rst_n) !(accept_c && tag_full));
   assert property (@(posedge clk) disable iff (!rst_n) tag_count == outstanding_q);
   assert property (@(posedge clk) disable iff (!rst_n) !(rsp_push_c && buf_full));

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: in-order imem model with variable latency,
// expected {instr, pc} entries queued on response and compared as decode consumes them.
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   localparam int DEPTH = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              stall, itr, IW, flush;
   logic [31:0]       redirect_pc;
   logic              imem_req_valid, imem_req_ready;
   logic [31:0]       imem_addr;
   logic              imem_rsp_valid;
   logic [31:0]       imem_rsp_data;
   fetchTOdecode_s    fetchTOdecode_s_o;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0]       perf_bubble_cnt, perf_discard_cnt;
`endif

   fetch_stage dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .stall             (stall),
      .itr               (itr),
      .IW                (IW),
      .flush             (flush),
      .redirect_pc       (redirect_pc),
      .imem_req_valid    (imem_req_valid),
      .imem_req_ready    (imem_req_ready),
      .imem_addr         (imem_addr),
      .imem_rsp_valid    (imem_rsp_valid),
      .imem_rsp_data     (imem_rsp_data),
      .fetchTOdecode_s_o (fetchTOdecode_s_o)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_bubble_cnt   (perf_bubble_cnt),
      .perf_discard_cnt  (perf_discard_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      int          due;
   } mreq_t;

   int           n_chk = 0;
   int           n_fail = 0;
   int           cyc = 0;
   logic [63:0]  sb[$];
   mreq_t        memq[$];
   logic [31:0]  exp_addr;
   int           b_out, b_disc;
   bit           running;
   int           lat_min = 1, lat_max = 1;
   logic [31:0]  b_bubble, b_drop;

   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return (pc ^ 32'h5A5A_0000) + 32'h0000_1001;
   endfunction

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; stall = 1'b0; itr = 1'b0; IW = 1'b0; flush = 1'b0;
      redirect_pc = 32'h0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
      memq.delete(); sb.delete();
      b_out = 0; b_disc = 0; exp_addr = 32'h0; running = 1'b0; b_bubble = 32'h0; b_drop = 32'h0;
      for (int k = 0; k < 2; k++) begin
         #1;
         check("rst_req_valid", 64'(imem_req_valid), 64'd0);
         check("rst_out", fetchTOdecode_s_o, {kNOP, 32'h0});
`ifdef FETCH_PERF_CNT_EN
         check("rst_perf_bubble", 64'(perf_bubble_cnt), 64'd0);
`endif
         @(negedge clk);
      end
   endtask

   // One clock: drive inputs at negedge, sample 1 time unit later, advance the model
   task automatic cycle(input logic s, input logic i, input logic w, input logic f,
                        input logic [31:0] rpc, input logic rdy);
      logic        rsp, e_req;
      logic [63:0] exp_out;
      mreq_t       m;
      @(negedge clk);
      rst_n = 1'b1; stall = s; itr = i; IW = w; flush = f; redirect_pc = rpc; imem_req_ready = rdy;
      rsp = (memq.size() > 0) && (memq[0].due <= cyc);
      imem_rsp_valid = rsp;
      imem_rsp_data  = rsp ? instr_of(memq[0].pc) : 32'h0;
      #1;
      e_req = running && ((sb.size() + b_out) < DEPTH) && !f;
      check("req_valid", 64'(imem_req_valid), 64'(e_req));
      exp_out = (sb.size() > 0) ? sb[0] : {kNOP, exp_addr};
      check("fetch_out", fetchTOdecode_s_o, exp_out);
`ifdef FETCH_PERF_CNT_EN
      check("perf_bubble", 64'(perf_bubble_cnt), 64'(b_bubble));
      check("perf_discard", 64'(perf_discard_cnt), 64'(b_drop));
      if ((sb.size() == 0) && !(s || i || w || f)) b_bubble++;
`endif
      if (!(s || i) && !w && !f && (sb.size() > 0)) void'(sb.pop_front());
      if (e_req && rdy) begin
         check("imem_addr", 64'(imem_addr), 64'(exp_addr));
         memq.push_back('{pc: exp_addr, due: cyc + int'($urandom_range(lat_max, lat_min))});
         exp_addr += 32'd4;
         b_out++;
      end
      if (rsp) begin
         m = memq.pop_front();
         b_out--;
         if (b_disc > 0) begin
            b_disc--;
            b_drop++;
         end else if (!f) begin
            sb.push_back({instr_of(m.pc), m.pc});
         end
      end
      if (f) begin
         sb.delete();
         exp_addr = rpc;
         b_disc   = b_out;
      end
      running = 1'b1;
      cyc++;
   endtask

   task automatic run(input int n, input logic rdy);
      for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, rdy);
   endtask

   initial begin
      bit found;
      rst_n = 1'b0;
      do_reset();

      // Back-to-back fetch, 1-cycle memory
      lat_min = 1; lat_max = 1;
      run(12, 1'b1);

      // Stall with the queue filling, then release
      for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      run(6, 1'b1);

      // Flush to 0x100 with slower memory so responses are in flight
      lat_min = 3; lat_max = 3;
      run(4, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 1'b1);
      run(10, 1'b1);

      // Flush coincident with stall and a response arrival
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         if ((memq.size() > 0) && (memq[0].due <= cyc)) begin
            found = 1'b1;
            cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 1'b1);
         end else begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
         end
      end
      check("flush_rsp_window", 64'(found), 64'd1);
      run(8, 1'b1);

      // IW holds the head; then drain to an empty queue
      lat_min = 1; lat_max = 1;
      run(4, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      run(8, 1'b0);

      // PC wrap at the top of the address space
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
      run(2, 1'b0);
      run(8, 1'b1);

      // Randomised controls and latency
      lat_min = 1; lat_max = 4;
      for (int k = 0; k < 300; k++) begin
         logic f;
         f = ($urandom_range(15, 0) == 0);
         cycle(logic'($urandom_range(3, 0) == 0), logic'($urandom_range(7, 0) == 0),
               logic'($urandom_range(7, 0) == 0), f,
               {$urandom_range(32'h0000_FFFF, 0), 2'b00} & 32'h0003_FFFC,
               logic'($urandom_range(3, 0) != 0));
      end

      // Reset mid-operation, then resume
      do_reset();
      lat_min = 2; lat_max = 2;
      run(10, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
